boe_stream_tx: RTL and testbench
================================

Name: boe_stream_tx

Overview:
- Producer side of the BOE sample interface.
- Collects one frame of 1..6 unsigned 8-bit samples from an upstream host through a valid/ready handshake.
- Replays the frame to a BOE engine on its `data_num`/`data_in` inputs with the exact cycle timing the engine expects.
- Holds the line idle for the engine's result phase (max, sum, sorted output) before accepting the next frame.

Parameters:
- MAX_N, 6, maximum samples per frame; also the buffer depth.
- DW, 8, sample width.
- NW, 3, width of the `data_num` field.
- RES_GAP, 2, extra idle cycles after the sorted phase (MAX and SUM result cycles).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-low (0 = reset, sampled on rising `clk`).
- in_valid  input  1  host sample valid.
- in_data  input  DW  host sample.
- in_last  input  1  marks the final sample of a frame.
- in_ready  output  1  block accepts a sample this cycle.
- data_num  output  NW  frame length; non-zero only on the first sample cycle.
- data_in  output  DW  sample to the engine.
- busy  output  1  high whenever state is not LOAD.
- frame_done  output  1  one-cycle pulse on the last wait cycle.
- frame_cnt  output  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- States: LOAD, SEND, WAIT. State encoding and n live in registers; outputs decode registers only, with no input-to-output combinational path.
- Reset (`rst` = 0 at a clock edge):
  - state = LOAD; wr_cnt, idx, gap_cnt, n = 0; frame_cnt = 0.
  - Outputs: `data_num` = 0, `data_in` = 0, `busy` = 0, `frame_done` = 0, `in_ready` = 0 during the reset cycle.
  - Buffer contents are don't-care and are not cleared.
  - Reset mid-SEND or mid-WAIT aborts the frame immediately; the partial frame is discarded.
- LOAD:
  - `in_ready` = 1.
  - On `in_valid`&&`in_ready`: buf[wr_cnt] <= `in_data`, wr_cnt++.
  - Accept with `in_last` = 1, or accept at wr_cnt == MAX_N-1 (forced last, `in_last` ignored): n <= wr_cnt+1, wr_cnt <= 0, idx <= 0, next state SEND.
  - `in_valid` with `in_ready` = 0 is not consumed; the host holds its data.
- SEND: lasts n cycles.
  - `data_in` = buf[idx].
  - `data_num` = n when idx == 0, else 0.
  - `in_ready` = 0.
  - idx++ each cycle. At idx == n-1: gap_cnt <= n+RES_GAP-1, next state WAIT.
- WAIT: lasts n+RES_GAP cycles.
  - `data_num` = 0, `data_in` = 0, `in_ready` = 0.
  - gap_cnt-- each cycle.
  - At gap_cnt == 0: `frame_done` = 1 this cycle, frame_cnt++ at the edge, next state LOAD.
- Latency:
  - Final accept at cycle t.
  - Sample k on `data_in` at cycle t+1+k (k = 0..n-1).
  - WAIT covers cycles t+n+1 .. t+2n+2.
  - `in_ready` returns high at cycle t+2n+3.
- Frame cost: n accept cycles (minimum) + 2n+2 output cycles.
- Boundaries:
  - n = 1: one SEND cycle, three WAIT cycles.
  - n = 6: a seventh `in_valid` is held off by `in_ready` = 0.
  - `in_last` on the first sample is legal (n = 1). A zero-length frame is impossible.
  - `in_valid` low gaps inside LOAD are allowed; no timeout.
- Arithmetic: n in 1..6, fits NW; gap_cnt fits 4 bits; all comparisons unsigned.

Decomposition:
- boe_pkg:
  - MAX_N, DW, NW, RES_GAP.
  - State enum {LOAD, SEND, WAIT}.
  - Shared between this block and the BOE engine for frame-length and width agreement.
- One sub-module, boe_tx_buf: MAX_N x DW register file with one write port (wr_en, wr_addr, wr_data) and one combinational read port (rd_addr). The controller FSM stays in boe_stream_tx.

Test Plan:
- Reset, then frame {9,3,7} with `in_last` on 7 -> `data_num` = 3 with `data_in` = 9, then data 3, 7 with `data_num` = 0; 5 idle cycles; `frame_done` pulse; frame_cnt = 1.
- Single sample 200 with `in_last` -> one SEND cycle (`data_num` = 1, `data_in` = 200), 3 WAIT cycles, `in_ready` high 5 cycles after the accept.
- Six samples {1..6} with no `in_last`, and `in_valid` kept high with 99 as a 7th sample -> forced last after 6; `data_num` = 6 once; 99 is not accepted until `in_ready` returns 15 cycles after the 6th accept; 99 then becomes the first sample of the next frame.
- Host inserts `in_valid` = 0 gaps between samples {50,0,255,0} -> no duplication or loss; output order 50,0,255,0; `data_num` = 4.
- Assert `rst` = 0 during the 2nd SEND cycle of a 5-sample frame -> next cycle all outputs 0, state LOAD, frame_cnt = 0; the following frame {4,4} transmits correctly.
- Back-to-back 256 frames of n = 2 -> frame_cnt wraps to 0; every frame spaced exactly 2n+2 output cycles plus accept cycles.

Source files
------------

// File: rtl/boe_pkg.sv
// Shared constants and state type for the BOE sample producer and the BOE engine.
package boe_pkg;

  localparam int MAX_N   = 6;
  localparam int DW      = 8;
  localparam int NW      = 3;
  localparam int RES_GAP = 2;
  localparam int AW      = $clog2(MAX_N);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/boe_stream_tx_if.sv
// Host-side valid/ready sample channel feeding boe_stream_tx.
interface boe_stream_tx_if;
  import boe_pkg::*;

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/boe_tx_buf.sv
// Frame buffer: MAX_N x DW register file, one write port, combinational read.
module boe_tx_buf
  import boe_pkg::*;
(
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [MAX_N];

  // Contents are intentionally not reset; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < AW'(MAX_N))) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (rd_addr < AW'(MAX_N)) ? mem_q[rd_addr] : '0;

endmodule

// File: rtl/boe_stream_tx.sv
// Collects a 1..MAX_N sample frame from the host, replays it to the BOE engine,
// then idles through the engine's result phase before accepting the next frame.
module boe_stream_tx
  import boe_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  boe_stream_tx_if.slave host,
  output logic [NW-1:0]  data_num,
  output logic [DW-1:0]  data_in,
  output logic           busy,
  output logic           frame_done,
  output logic [7:0]     frame_cnt
);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [NW-1:0] n_q, n_d;
  logic [3:0]    gap_cnt_q, gap_cnt_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          accept;
  logic [DW-1:0] rd_data;

  assign accept = host.in_valid && host.in_ready;

  boe_tx_buf u_buf (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wr_cnt_q),
    .wr_data (host.in_data),
    .rd_addr (idx_q),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= LOAD;
      wr_cnt_q    <= '0;
      idx_q       <= '0;
      n_q         <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    idx_d       = idx_q;
    n_d         = n_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          // A full buffer closes the frame regardless of in_last.
          if (host.in_last || (wr_cnt_q == AW'(MAX_N - 1))) begin
            n_d      = NW'(wr_cnt_q) + NW'(1);
            wr_cnt_d = '0;
            idx_d    = '0;
            state_d  = SEND;
          end else begin
            wr_cnt_d = wr_cnt_q + AW'(1);
          end
        end
      end
      SEND: begin
        idx_d = idx_q + AW'(1);
        if (NW'(idx_q) == (n_q - NW'(1))) begin
          gap_cnt_d = 4'(n_q) + 4'(RES_GAP - 1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (gap_cnt_q == 4'd0) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          state_d     = LOAD;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Outputs are a decode of registered state; forced quiet while reset is applied.
  always_comb begin
    host.in_ready = 1'b0;
    data_num      = '0;
    data_in       = '0;
    busy          = 1'b0;
    frame_done    = 1'b0;
    if (rst) begin
      unique case (state_q)
        LOAD: host.in_ready = 1'b1;
        SEND: begin
          busy     = 1'b1;
          data_in  = rd_data;
          data_num = (idx_q == '0) ? n_q : '0;
        end
        WAIT: begin
          busy       = 1'b1;
          frame_done = (gap_cnt_q == 4'd0);
        end
        default: busy = 1'b1;
      endcase
    end
  end

  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_boe_stream_tx.sv
// Bench for boe_stream_tx: frame-level timeline model checked every cycle plus directed literal checks.
module tb_boe_stream_tx;
  import boe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NW-1:0] data_num;
  logic [DW-1:0] data_in;
  logic busy, frame_done;
  logic [7:0] frame_cnt;

  boe_stream_tx_if hif ();

  boe_stream_tx dut (
    .clk        (clk),
    .rst        (rst),
    .host       (hif),
    .data_num   (data_num),
    .data_in    (data_in),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endfunction

  // ---------------- timeline model ----------------
  // A frame closed (last accept) at cycle t_c with n_m samples occupies cycles
  // t_c+1 .. t_c+2n+2; samples appear at t_c+1+k; the host is served again after end_c.
  bit           mdl_on = 1'b0;
  longint       t_c    = -100;
  longint       end_c  = -1;
  int           n_m    = 0;
  int           fc_m   = 0;
  logic [7:0]   fr [MAX_N];
  logic [7:0]   coll [$];
  logic         e_rdy, e_busy, e_done;
  logic [NW-1:0] e_num;
  logic [7:0]   e_dat;
  longint       off;

  always @(negedge clk) begin
    e_rdy = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_num = '0; e_dat = '0;
    if (rst === 1'b0) begin
      mdl_on = 1'b1;
      chk("rst_in_ready", 32'(hif.in_ready), 32'(e_rdy));
      chk("rst_busy", 32'(busy), 32'(e_busy));
      chk("rst_data_num", 32'(data_num), 32'(e_num));
      chk("rst_data_in", 32'(data_in), 32'(e_dat));
      chk("rst_frame_done", 32'(frame_done), 32'(e_done));
      coll.delete();
      end_c = cyc;
      t_c   = -100;
      fc_m  = 0;
    end else if (mdl_on) begin
      if (cyc > end_c) begin
        e_rdy = 1'b1;
      end else begin
        e_busy = 1'b1;
        off = cyc - t_c;
        if (off >= 1 && off <= n_m) begin
          e_dat = fr[off-1];
          e_num = (off == 1) ? NW'(n_m) : '0;
        end
        e_done = (cyc == end_c);
      end
      chk("in_ready", 32'(hif.in_ready), 32'(e_rdy));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("data_num", 32'(data_num), 32'(e_num));
      chk("data_in", 32'(data_in), 32'(e_dat));
      chk("frame_done", 32'(frame_done), 32'(e_done));
      chk("frame_cnt", 32'(frame_cnt), 32'(fc_m));
      if (e_rdy && hif.in_valid === 1'b1) begin
        coll.push_back(hif.in_data);
        if (hif.in_last === 1'b1 || coll.size() == MAX_N) begin
          n_m = coll.size();
          for (int k = 0; k < n_m; k++) fr[k] = coll[k];
          coll.delete();
          t_c   = cyc;
          end_c = cyc + 2 * n_m + 2;
        end
      end
      if (e_done) fc_m = (fc_m + 1) % 256;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d, input logic last);
    int  w;
    bit  done;
    w = 0; done = 1'b0;
    hif.in_valid = 1'b1; hif.in_data = d; hif.in_last = last;
    while (!done) begin
      @(negedge clk);
      if (hif.in_ready === 1'b1) begin
        done = 1'b1;
      end else begin
        w++;
        if (w > 200) begin
          total++; bad++;
          $display("FAIL put_timeout: in_ready low for %0d cycles, expected high within 200", w);
          done = 1'b1;
        end
      end
    end
    sync();
    hif.in_valid = 1'b0; hif.in_last = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 200);
    if (frame_done !== 1'b1) begin
      total++; bad++;
      $display("FAIL wait_done_timeout: frame_done=%0b after %0d cycles, expected 1", frame_done, n);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (hif.in_ready !== 1'b1 && n < 200);
    if (hif.in_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL wait_ready_timeout: in_ready=%0b after %0d cycles, expected 1", hif.in_ready, n);
    end
  endtask

  // ---------------- directed sequence ----------------
  int cnt;
  longint prev_done;

  initial begin
    hif.in_valid = 1'b0; hif.in_data = '0; hif.in_last = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset_in_ready", 32'(hif.in_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    sync();

    // Frame {9,3,7}
    put(8'd9, 1'b0); put(8'd3, 1'b0); put(8'd7, 1'b1);
    @(negedge clk);
    chk("f1_first_num", 32'(data_num), 32'd3);
    chk("f1_first_data", 32'(data_in), 32'd9);
    @(negedge clk);
    chk("f1_second_data", 32'(data_in), 32'd3);
    chk("f1_second_num", 32'(data_num), 32'd0);
    @(negedge clk);
    chk("f1_third_data", 32'(data_in), 32'd7);
    wait_done(cnt);
    chk("f1_wait_cycles", 32'(cnt), 32'd5);
    @(negedge clk);
    chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("f1_ready_back", 32'(hif.in_ready), 32'd1);
    sync();

    // Single sample 200
    put(8'd200, 1'b1);
    wait_ready(cnt);
    chk("n1_ready_latency", 32'(cnt), 32'd5);
    sync();

    // Six samples, forced last, 99 held off
    for (int i = 1; i <= 6; i++) put(8'(i), 1'b0);
    hif.in_valid = 1'b1; hif.in_data = 8'd99; hif.in_last = 1'b0;
    @(negedge clk);
    chk("n6_first_num", 32'(data_num), 32'd6);
    chk("n6_held_off", 32'(hif.in_ready), 32'd0);
    wait_ready(cnt);
    chk("n6_ready_latency", 32'(cnt + 1), 32'd15);
    sync();
    hif.in_valid = 1'b0;
    // 99 was taken at the previous edge; close the frame {99,5}
    put(8'd5, 1'b1);
    @(negedge clk);
    chk("carry_first_data", 32'(data_in), 32'd99);
    chk("carry_first_num", 32'(data_num), 32'd2);
    wait_ready(cnt);
    sync();

    // Gapped host {50,0,255,0}
    put(8'd50, 1'b0); repeat (2) sync();
    put(8'd0, 1'b0);  repeat (3) sync();
    put(8'd255, 1'b0); sync();
    put(8'd0, 1'b1);
    @(negedge clk);
    chk("gap_first_num", 32'(data_num), 32'd4);
    chk("gap_first_data", 32'(data_in), 32'd50);
    wait_ready(cnt);
    sync();

    // Reset during second SEND cycle of a 5-sample frame
    put(8'd10, 1'b0); put(8'd20, 1'b0); put(8'd30, 1'b0); put(8'd40, 1'b0); put(8'd50, 1'b1);
    sync();
    rst = 1'b0;
    sync();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_data_num", 32'(data_num), 32'd0);
    chk("abort_data_in", 32'(data_in), 32'd0);
    chk("abort_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("abort_in_ready", 32'(hif.in_ready), 32'd1);
    sync();
    put(8'd4, 1'b0); put(8'd4, 1'b1);
    @(negedge clk);
    chk("after_abort_num", 32'(data_num), 32'd2);
    chk("after_abort_data", 32'(data_in), 32'd4);
    wait_ready(cnt);
    sync();

    // 256 back-to-back frames of n=2 from a clean count
    rst = 1'b0;
    sync();
    rst = 1'b1;
    prev_done = 0;
    for (int i = 0; i < 256; i++) begin
      put(8'(i), 1'b0);
      put(8'(i) ^ 8'hA5, 1'b1);
      wait_done(cnt);
      if (i > 0) chk("b2b_spacing", 32'(cyc - prev_done), 32'd8);
      prev_done = cyc;
      sync();
    end
    @(negedge clk);
    chk("wrap_frame_cnt", 32'(frame_cnt), 32'd0);
    sync();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
